// File: rtl/sirv_tl_reg_master.sv
// sirv_tl_reg_master: single-outstanding TL-UL initiator bridging a cmd/rsp register port to A/D channels.
module sirv_tl_reg_master #(
  parameter logic [4:0] SOURCE_ID = 5'd0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [28:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic        tl_a_valid,
  input  logic        tl_a_ready,
  output logic [2:0]  tl_a_bits_opcode,
  output logic [2:0]  tl_a_bits_param,
  output logic [2:0]  tl_a_bits_size,
  output logic [4:0]  tl_a_bits_source,
  output logic [28:0] tl_a_bits_address,
  output logic [3:0]  tl_a_bits_mask,
  output logic [31:0] tl_a_bits_data,
  input  logic        tl_d_valid,
  output logic        tl_d_ready,
  input  logic [2:0]  tl_d_bits_opcode,
  input  logic [1:0]  tl_d_bits_param,
  input  logic [2:0]  tl_d_bits_size,
  input  logic [4:0]  tl_d_bits_source,
  input  logic        tl_d_bits_sink,
  input  logic [1:0]  tl_d_bits_addr_lo,
  input  logic [31:0] tl_d_bits_data,
  input  logic        tl_d_bits_error
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_t;
  state_t state, state_nxt;
  logic        wr_q;
  logic [28:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        cap, tmo, d_err, a_act;
  logic        unused_d;
  assign unused_d = ^{tl_d_bits_param, tl_d_bits_size, tl_d_bits_sink, tl_d_bits_addr_lo};
  assign a_act             = state == REQ;
  assign cmd_ready         = state == IDLE;
  assign tl_a_valid        = a_act;
  assign tl_a_bits_opcode  = !a_act ? 3'd0 : !wr_q ? 3'd4 : mask_q == 4'hf ? 3'd0 : 3'd1;
  assign tl_a_bits_param   = 3'd0;
  assign tl_a_bits_size    = a_act ? 3'd2 : 3'd0;
  assign tl_a_bits_source  = a_act ? SOURCE_ID : 5'd0;
  assign tl_a_bits_address = a_act ? addr_q : 29'd0;
  assign tl_a_bits_mask    = a_act ? mask_q : 4'd0;
  assign tl_a_bits_data    = a_act && wr_q ? wdata_q : 32'd0;
  assign tl_d_ready        = state != RSP;
  assign rsp_valid         = state == RSP;
  assign rsp_rdata         = rdata_q;
  assign rsp_error         = err_q;
  assign d_err = tl_d_bits_error | (tl_d_bits_source != SOURCE_ID) |
                 (tl_d_bits_opcode != (wr_q ? 3'd0 : 3'd1));
`ifdef SIRV_TL_MASTER_TIMEOUT_EN
  logic [7:0] cnt;
  logic       to_q;
  assign tmo         = state == WAIT && !tl_d_valid && cnt == 8'(TIMEOUT_CYCLES - 1);
  assign rsp_timeout = to_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= 8'd0;
      to_q <= 1'b0;
    end else begin
      cnt <= state == WAIT ? cnt + 8'd1 : 8'd0;
      if (cap || tmo) to_q <= tmo;
    end
  end
`else
  assign tmo         = 1'b0;
  assign rsp_timeout = 1'b0;
`endif
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    case (state)
      IDLE: state_nxt = cmd_valid ? REQ : IDLE;
      REQ: begin
        cap       = tl_a_ready && tl_d_valid;
        state_nxt = !tl_a_ready ? REQ : tl_d_valid ? RSP : WAIT;
      end
      WAIT: begin
        cap       = tl_d_valid;
        state_nxt = tl_d_valid || tmo ? RSP : WAIT;
      end
      default: state_nxt = rsp_ready ? IDLE : RSP;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 29'd0;
      wdata_q <= 32'd0;
      mask_q  <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_ready && cmd_valid) begin
        wr_q    <= cmd_write;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        mask_q  <= cmd_mask;
      end
      if (cap || tmo) begin
        rdata_q <= cap && !wr_q && !d_err ? tl_d_bits_data : 32'd0;
        err_q   <= cap ? d_err : 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sirv_tl_reg_master.sv
// tb_sirv_tl_reg_master: scoreboarded bench; bench acts as the TL slave, monitor pops expected responses.
module tb_sirv_tl_reg_master;
  logic        clk = 1'b0, reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [28:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_mask = '0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        tl_a_valid, tl_a_ready = 1'b0;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [4:0]  a_source;
  logic [28:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        tl_d_valid = 1'b0, tl_d_ready;
  logic [2:0]  d_opcode = '0;
  logic [4:0]  d_source = '0;
  logic [31:0] d_data = '0;
  logic        d_error = 1'b0;
  int checks = 0, errors = 0, n_txn = 0, n_rsp = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  sirv_tl_reg_master #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready),
    .tl_a_bits_opcode(a_opcode), .tl_a_bits_param(a_param), .tl_a_bits_size(a_size),
    .tl_a_bits_source(a_source), .tl_a_bits_address(a_address), .tl_a_bits_mask(a_mask),
    .tl_a_bits_data(a_data),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready),
    .tl_d_bits_opcode(d_opcode), .tl_d_bits_param(2'd0), .tl_d_bits_size(3'd2),
    .tl_d_bits_source(d_source), .tl_d_bits_sink(1'b0), .tl_d_bits_addr_lo(2'd0),
    .tl_d_bits_data(d_data), .tl_d_bits_error(d_error)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      n_rsp++;
      if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
      else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e[33:2]);
        check("rsp_error", {31'd0, rsp_error}, {31'd0, e[1]});
        check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e[0]});
      end
    end
  end

  task automatic drive_d(input logic [2:0] op, input logic [4:0] src, input logic err, input logic [31:0] dat);
    tl_d_valid = 1'b1; d_opcode = op; d_source = src; d_error = err; d_data = dat;
  endtask

  task automatic txn(input logic w, input logic [28:0] a, input logic [31:0] wd, input logic [3:0] m,
                     input int stall, input int dly, input int hold,
                     input logic [2:0] dop, input logic [4:0] dsrc, input logic derr, input logic [31:0] drd);
    logic [2:0] eop;
    logic       eerr;
    eop  = !w ? 3'd4 : m == 4'hf ? 3'd0 : 3'd1;
    eerr = derr || dsrc != 5'd0 || dop != (w ? 3'd0 : 3'd1);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_mask = m;
    exp_q.push_back({(!w && !eerr) ? drd : 32'd0, eerr, 1'b0});
    n_txn++;
    tick();
    cmd_valid = 1'b0; cmd_wdata = ~wd; cmd_addr = ~a; cmd_mask = ~m;
    for (int i = 0; i <= stall; i++) begin
      if (i > 0) tick();
      check("a_valid", {31'd0, tl_a_valid}, 32'd1);
      check("a_opcode", {29'd0, a_opcode}, {29'd0, eop});
      check("a_address", {3'd0, a_address}, {3'd0, a});
      check("a_mask", {28'd0, a_mask}, {28'd0, m});
      check("a_data", a_data, w ? wd : 32'd0);
      check("a_size_src", {24'd0, a_size, a_source}, {24'd0, 3'd2, 5'd0});
      check("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      check("d_ready_req", {31'd0, tl_d_ready}, 32'd1);
    end
    tl_a_ready = 1'b1;
    if (dly == 0) drive_d(dop, dsrc, derr, drd);
    tick();
    tl_a_ready = 1'b0; tl_d_valid = 1'b0;
    if (dly > 0) begin
      for (int i = 0; i < dly; i++) begin
        check("a_valid_wait", {31'd0, tl_a_valid}, 32'd0);
        check("rsp_valid_wait", {31'd0, rsp_valid}, 32'd0);
        if (i == dly - 1) drive_d(dop, dsrc, derr, drd);
        tick();
      end
      tl_d_valid = 1'b0;
    end
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("d_ready_rsp", {31'd0, tl_d_ready}, 32'd0);
    if (hold > 0) begin
      rsp_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        tick();
        check("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
    end
    tick();
    check("cmd_ready_after", {31'd0, cmd_ready}, 32'd1);
    check("rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
  endtask

  task automatic stray(input logic [31:0] dat);
    check("d_ready_idle", {31'd0, tl_d_ready}, 32'd1);
    drive_d(3'd1, 5'd0, 1'b0, dat);
    tick();
    tl_d_valid = 1'b0;
    check("stray_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_d_ready", {31'd0, tl_d_ready}, 32'd1);
    check("rst_a_valid", {31'd0, tl_a_valid}, 32'd0);
    check("rst_a_bits", {a_opcode, a_param, a_size, a_source, a_mask, 14'd0}, 32'd0);
    check("rst_a_addr", {3'd0, a_address}, 32'd0);
    check("rst_a_data", a_data, 32'd0);
    check("rst_rsp", {28'd0, rsp_valid, rsp_error, rsp_timeout, 1'b0}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    txn(1'b0, 29'h1000_0008, 32'h0, 4'hf, 0, 0, 0, 3'd1, 5'd0, 1'b0, 32'h1234_5678);
    txn(1'b1, 29'h1000_000c, 32'hDEAD_BEEF, 4'hf, 0, 0, 0, 3'd0, 5'd0, 1'b0, 32'h5555_5555);
    txn(1'b1, 29'h1000_0010, 32'h0000_00A5, 4'h1, 0, 0, 0, 3'd0, 5'd0, 1'b0, 32'h0);
    txn(1'b0, 29'h0ABC_0004, 32'h0, 4'h6, 5, 3, 4, 3'd1, 5'd0, 1'b0, 32'hCAFE_F00D);
    txn(1'b1, 29'h1000_0020, 32'h1111_2222, 4'hf, 0, 1, 0, 3'd0, 5'd0, 1'b1, 32'h0);
    txn(1'b0, 29'h1000_0024, 32'h0, 4'hf, 0, 0, 0, 3'd1, 5'd3, 1'b0, 32'h7777_8888);
    txn(1'b0, 29'h1000_0028, 32'h0, 4'hf, 1, 2, 0, 3'd0, 5'd0, 1'b0, 32'h9999_AAAA);
    stray(32'hBAD0_BAD0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 29'h40; cmd_mask = 4'hf;
    tick();
    cmd_valid = 1'b0;
    check("mid_a_valid", {31'd0, tl_a_valid}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("mid_rst_a_valid", {31'd0, tl_a_valid}, 32'd0);
    stray(32'h0BAD_0BAD);
    txn(1'b0, 29'h44, 32'h0, 4'h3, 0, 0, 0, 3'd1, 5'd0, 1'b0, 32'h0102_0304);
`ifdef SIRV_TL_MASTER_TIMEOUT_EN
    begin
      int k;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 29'h80; cmd_mask = 4'hf;
      exp_q.push_back({32'd0, 1'b1, 1'b1});
      n_txn++;
      tick();
      cmd_valid = 1'b0;
      tl_a_ready = 1'b1;
      tick();
      tl_a_ready = 1'b0;
      k = 0;
      while (!rsp_valid && k < 40) begin
        tick();
        k++;
      end
      check("timeout_wait_cycles", k, 16);
      tick();
      stray(32'hDEAD_DEAD);
      txn(1'b0, 29'h84, 32'h0, 4'hf, 0, 0, 0, 3'd1, 5'd0, 1'b0, 32'h4242_4242);
    end
`endif
    repeat (2) tick();
    check("rsp_count", n_rsp, n_txn);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
